// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: digit sequencing with blank gaps,
// frame-boundary value updates through a one-deep pending slot, leading-zero blanking.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank_lz,
  output logic [3:0]              dec_nibble,
  input  logic [7:0]              dec_seg,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt, w_cnt_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] r_active, r_pending;
  logic                    r_pfull;
  logic [7:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig_en;
  logic                    w_blank_end, w_show_end, w_last, w_wrap, w_xfer;
  logic                    w_upper_zero, w_lz_blank;

  assign w_blank_end = (r_state == BLANK) && (r_cnt == CW'(BLANK_CYCLES - 1));
  assign w_show_end  = (r_state == SHOW) && (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_last      = (r_idx == IW'(NUM_DIGITS - 1));
  assign w_wrap      = w_show_end && w_last;
  assign w_xfer      = load_valid && !r_pfull;

  assign dec_nibble  = r_active[4*r_idx +: 4];
  assign load_ready  = !r_pfull;
  assign frame_done  = w_wrap;
  assign seg_o       = r_seg;
  assign dig_en_o    = r_dig_en;

  // Digit idx is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    w_upper_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((IW'(j) >= r_idx) && (r_active[4*j +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
    w_lz_blank = blank_lz && (r_idx != '0) && w_upper_zero;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_idx;
    case (r_state)
      BLANK: if (w_blank_end) begin
        w_state_nxt = SHOW;
        w_cnt_nxt   = '0;
      end
      SHOW: if (w_show_end) begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = w_last ? '0 : r_idx + 1'b1;
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Segment bus and digit enables only move on BLANK<->SHOW edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= '0;
      r_dig_en <= '0;
    end else if (w_blank_end) begin
      r_seg    <= w_lz_blank ? '0 : dec_seg;
      r_dig_en <= NUM_DIGITS'(1) << r_idx;
    end else if (w_show_end) begin
      r_seg    <= '0;
      r_dig_en <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_pending <= '0;
      r_pfull   <= 1'b0;
    end else if (w_wrap && r_pfull) begin
      r_active <= r_pending;
      r_pfull  <= 1'b0;
    end else if (w_xfer) begin
      r_pending <= value_i;
      r_pfull   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame/phase arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 2;
  localparam int P = B + R;
  localparam int F = N * P;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] value_i = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        blank_lz = 1'b0;
  logic [3:0]  dec_nibble;
  logic [7:0]  dec_seg;
  logic [7:0]  seg_o;
  logic [3:0]  dig_en_o;
  logic        frame_done;
  logic [21:0] dut_vec;

  int total = 0;
  int bad   = 0;

  // Reference model: k = rising edges since reset release.
  int          k;
  logic [15:0] m_active, m_pending;
  logic        m_pfull;
  logic [7:0]  m_seg;
  logic [21:0] exp_vec;

  display_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_valid(load_valid),
    .load_ready(load_ready), .blank_lz(blank_lz), .dec_nibble(dec_nibble),
    .dec_seg(dec_seg), .seg_o(seg_o), .dig_en_o(dig_en_o), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] t [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                           8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    return t[n];
  endfunction

  assign dec_seg = seg_of(dec_nibble);
  assign dut_vec = {seg_o, dig_en_o, frame_done, load_ready, dec_nibble, 4'h0};

  task automatic model_reset();
    k = 0; m_active = '0; m_pending = '0; m_pfull = 1'b0; m_seg = '0;
  endtask

  task automatic step();
    logic        xfer, lz;
    logic [15:0] vin;
    int          p, d;
    logic [7:0]  eseg;
    logic [3:0]  een;
    xfer = load_valid && !m_pfull;
    lz   = blank_lz;
    vin  = value_i;
    @(posedge clk);
    k++;
    if ((k % F == 0) && m_pfull) begin
      m_active = m_pending;
      m_pfull  = 1'b0;
    end
    if (xfer) begin
      m_pending = vin;
      m_pfull   = 1'b1;
    end
    p = k % P;
    d = (k / P) % N;
    if (p == B)
      m_seg = (lz && d > 0 && (m_active >> (4*d)) == 16'h0) ? 8'h00 : seg_of(m_active[4*d +: 4]);
    een  = (p >= B) ? 4'(1 << d) : 4'd0;
    eseg = (p >= B) ? m_seg : 8'h00;
    exp_vec = {eseg, een, (k % F == F - 1), !m_pfull, m_active[4*d +: 4], 4'h0};
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    total++;
    if ({seg_o, dig_en_o, frame_done, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_vals got=%h exp=%h", {seg_o, dig_en_o, frame_done, load_ready}, {8'h00, 4'h0, 1'b0, 1'b1});
    end
    @(posedge clk);
    release_reset();
  endtask

  task automatic test_scan();
    blank_lz = 1'b0;
    for (int i = 0; i < 2*F; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL scan k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_load_midframe();
    for (int i = 0; i < F && (k % F != 10); i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL mid_wait k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    value_i = 16'h0812; load_valid = 1'b1;
    step(); total++;
    if (dut_vec !== exp_vec) begin bad++; $display("FAIL mid_accept k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    load_valid = 1'b0; value_i = 16'($urandom);
    for (int i = 0; i < 2*F; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL mid_run k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_hold();
    int acc = 0;
    value_i = 16'($urandom); load_valid = 1'b1;
    for (int i = 0; i < 3*F && acc < 2; i++) begin
      logic will;
      will = !m_pfull;
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL hold k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (will) begin
        acc++;
        value_i = 16'($urandom);
        if (acc == 2) load_valid = 1'b0;
      end
    end
    load_valid = 1'b0;
    for (int i = 0; i < 2*F; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL hold_run k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_wrap_load();
    for (int i = 0; i < 3*F && (m_pfull || (k % F != F - 1)); i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL wrap_wait k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("FAIL wrap_frame_done got=%b exp=1", frame_done); end
    value_i = 16'h2108; load_valid = 1'b1;
    step(); total++;
    if (dut_vec !== exp_vec) begin bad++; $display("FAIL wrap_accept k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    load_valid = 1'b0;
    for (int i = 0; i < 2*F + 4; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL wrap_run k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_lz();
    blank_lz = 1'b1;
    value_i = 16'h0001; load_valid = 1'b1;
    for (int i = 0; i < 3*F && load_valid; i++) begin
      logic will;
      will = !m_pfull;
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL lz_load k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (will) load_valid = 1'b0;
    end
    load_valid = 1'b0;
    for (int i = 0; i < 3*F; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL lz_run k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [5] = '{16'h000F, 16'h00FF, 16'h0F0F, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 10*F; i++) begin
      if ($urandom_range(0, 7) == 0) blank_lz = 1'($urandom);
      load_valid = ($urandom_range(0, 3) == 0);
      value_i    = 16'($urandom) & masks[$urandom_range(0, 4)];
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_midshow();
    blank_lz = 1'b0;
    for (int i = 0; i < 2*F && m_pfull; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL rst_drain k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    value_i = 16'h8421; load_valid = 1'b1;
    step(); total++;
    if (dut_vec !== exp_vec) begin bad++; $display("FAIL rst_load k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    load_valid = 1'b0;
    for (int i = 0; i < 2*F && !(m_pfull && (k % F == 15)); i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL rst_wait k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    total++;
    if ({dig_en_o, load_ready} !== {4'b0100, 1'b0}) begin
      bad++; $display("FAIL rst_precond got=%h exp=%h", {dig_en_o, load_ready}, {4'b0100, 1'b0});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({seg_o, dig_en_o, frame_done, load_ready} !== {8'h00, 4'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rst_async got=%h exp=%h", {seg_o, dig_en_o, frame_done, load_ready}, {8'h00, 4'h0, 1'b0, 1'b1});
    end
    release_reset();
    for (int i = 0; i < F; i++) begin
      step(); total++;
      if (dut_vec !== exp_vec) begin bad++; $display("FAIL rst_restart k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    total++;
    if (dut.r_active !== 16'h0000) begin bad++; $display("FAIL rst_active got=%h exp=0000", dut.r_active); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_load_midframe();
    test_hold();
    test_wrap_load();
    test_lz();
    test_random();
    test_reset_midshow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
